instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning output buffer entries (legal values 2..4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, with synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning upstream offers an instruction.
REQ-005 SHALL have port in_ready, output, 1, meaning the encoder accepts this cycle.
REQ-006 SHALL have port in_class, input, 4, meaning instruction class (R, I, STORE, LOAD, BRANCH, JALR, JAL, AUIPC, LUI).
REQ-007 SHALL have port in_funct3, input, 3, meaning funct3 field.
REQ-008 SHALL have port in_alt, input, 1, meaning funct7[5] select (SUB/SRA/SRAI).
REQ-009 SHALL have ports in_rd, in_rs1 and in_rs2, each input, 5, meaning register ids.
REQ-010 SHALL have port in_imm, input, 32, meaning the full-width immediate as the decoder reconstructs it.
REQ-011 SHALL have port out_valid, output, 1, meaning an encoded word is available.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer takes the word.
REQ-013 SHALL have port out_instr, output, 32, meaning the RV32I encoded instruction.
REQ-014 SHALL have port out_err, output, 1, meaning this entry failed encoding.
REQ-015 SHALL have port enc_count, output, 16, meaning the number of error-free words accepted.

Function
REQ-016 Encoding SHALL follow RV32I base formats: R, I, S, B, U, J; opcodes 0110011, 0010011, 0100011, 0000011, 1100011, 1100111, 1101111, 0010111, 0110111.
REQ-017 R class SHALL set funct7 to 0100000 when in_alt=1 and funct3 is 000 or 101, and SHALL set funct7 to 0000000 otherwise.
REQ-018 I class with funct3 001 or 101 SHALL encode shamt=in_imm[4:0] and funct7 = in_alt?0100000:0000000.
REQ-019 Range checks SHALL set the error condition as follows.
  - I, LOAD, JALR, STORE: in_imm not sign-extension of its bits [11:0].
  - BRANCH: not a 13-bit signed value, or in_imm[0]=1.
  - JAL: not a 21-bit signed value, or in_imm[0]=1.
  - LUI, AUIPC: in_imm[11:0] != 0.
  - Shifts: in_imm[31:5] != 0.
  - BRANCH funct3 010 or 011.
  - Unknown class.
REQ-020 An error entry SHALL carry out_instr=32'h0 and out_err=1, and SHALL still occupy one buffer slot in order.
REQ-021 A transfer SHALL occur when in_valid and in_ready are both 1; the encoded result SHALL be written into the FIFO at that edge.
REQ-022 Latency SHALL be exactly 1 cycle: a word accepted at edge N SHALL present out_valid=1 after edge N when the buffer was empty.
REQ-023 in_ready SHALL equal (count != DEPTH) and SHALL depend on count only, with no combinational path from out_ready.
REQ-024 Pop SHALL occur when out_valid and out_ready are both 1; out_valid SHALL equal (count != 0).
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-026 Output ports SHALL be driven from the head entry; head SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 enc_count SHALL increment on each accepted error-free word and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-029 While rst=1 the block SHALL drive count=0, pointers=0, enc_count=0, out_valid=0, out_instr=0 and out_err=0, and in_ready=0 for the reset cycle.
REQ-030 Reset SHALL discard buffered entries mid-operation; a handshake coinciding with rst=1 SHALL be ignored.
REQ-031 in_ready SHALL return to 1 on the first cycle after rst deasserts.

Structure
REQ-032 Class encodings, opcode constants and format field positions SHALL live in the shared package (rv_pkg), shared with the decoder and ALU op defines.
REQ-033 The combinational field packer SHALL be one sub-module, instr_pack, covering fields to word plus error; the FIFO SHALL stay in instr_encoder.

Verification
REQ-034 The bench SHALL cover I class, funct3 000, rd=1, rs1=0, imm=5 -> out_instr=32'h00500093, out_err=0, one cycle later.
REQ-035 The bench SHALL cover R class, alt=1, funct3 000, rd=3, rs1=1, rs2=2 -> 32'h402081B3.
REQ-036 The bench SHALL cover LUI rd=5, imm=32'h12345000 -> 32'h123452B7; then JAL rd=1, imm=8 -> 32'h008000EF.
REQ-037 The bench SHALL cover BRANCH funct3 000, imm=3 -> out_err=1, out_instr=0, enc_count unchanged.
REQ-038 The bench SHALL cover out_ready=0 with three offers, which SHALL show in_ready low after 2 accepts; releasing out_ready SHALL drain the words in order, and simultaneous push/pop SHALL be checked.
REQ-039 The bench SHALL cover rst=1 with 2 entries buffered -> out_valid=0 and enc_count=0 next cycle, and in_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/rv_pkg.sv
// RV32I encoding constants shared by the encoder, the decoder and the ALU.
// Holds instruction class codes, opcodes, field positions and an immediate range helper.
package rv_pkg;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I      = 4'd1,
        CLS_STORE  = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JALR   = 4'd5,
        CLS_JAL    = 4'd6,
        CLS_AUIPC  = 4'd7,
        CLS_LUI    = 4'd8
    } cls_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // True when v is the sign extension of its low 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= bits - 1 && v[i] != v[31]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns class plus operand fields into an RV32I word.
// Any range or class violation zeroes the word and raises err_o.
module instr_pack
    import rv_pkg::*;
(
    input  logic [3:0]  cls_i,
    input  logic [2:0]  funct3_i,
    input  logic        alt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic [31:0] word;
    logic        err;
    logic [6:0]  f7_r;
    logic        is_shift;

    always_comb begin
        word     = '0;
        err      = 1'b0;
        f7_r     = (alt_i && (funct3_i == 3'b000 || funct3_i == 3'b101)) ? F7_ALT : F7_BASE;
        is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);
        case (cls_i)
            CLS_R: word = {f7_r, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
            CLS_I: begin
                if (is_shift) begin
                    err  = |imm_i[31:5];
                    word = {(alt_i ? F7_ALT : F7_BASE), imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
                end else begin
                    err  = !fits_signed(imm_i, 12);
                    word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
                end
            end
            CLS_LOAD: begin
                err  = !fits_signed(imm_i, 12);
                word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
            end
            CLS_JALR: begin
                err  = !fits_signed(imm_i, 12);
                word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_JALR};
            end
            CLS_STORE: begin
                err  = !fits_signed(imm_i, 12);
                word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
            end
            CLS_BRANCH: begin
                // funct3 010/011 are unassigned branch encodings
                err  = !fits_signed(imm_i, 13) || imm_i[0] ||
                       funct3_i == 3'b010 || funct3_i == 3'b011;
                word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], OPC_BRANCH};
            end
            CLS_JAL: begin
                err  = !fits_signed(imm_i, 21) || imm_i[0];
                word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
            end
            CLS_AUIPC: begin
                err  = |imm_i[11:0];
                word = {imm_i[31:12], rd_i, OPC_AUIPC};
            end
            CLS_LUI: begin
                err  = |imm_i[11:0];
                word = {imm_i[31:12], rd_i, OPC_LUI};
            end
            default: err = 1'b1;
        endcase
        instr_o = err ? 32'h0 : word;
        err_o   = err;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs fields through instr_pack into a small output FIFO.
// in_ready depends only on occupancy, so there is no path from out_ready to in_ready.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_class,
    input  logic [2:0]  in_funct3,
    input  logic        in_alt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] enc_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pack_instr;
    logic             pack_err;
    logic [32:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      enc_count_q, enc_count_d;
    logic             push, pop;
    logic [32:0]      head;

    instr_pack u_pack (
        .cls_i    (in_class),
        .funct3_i (in_funct3),
        .alt_i    (in_alt),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .imm_i    (in_imm),
        .instr_o  (pack_instr),
        .err_o    (pack_err)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_ready    = !rst && (count_q != CNT_W'(DEPTH));
        out_valid   = !rst && (count_q != '0);
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
        head        = mem_q[rd_ptr_q];
        out_instr   = out_valid ? head[31:0] : 32'h0;
        out_err     = out_valid && head[32];
        enc_count   = enc_count_q;
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        enc_count_d = enc_count_q + 16'(push && !pack_err);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            enc_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            enc_count_q <= enc_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {pack_err, pack_instr};
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=2) with hand-computed RV32I words.
module tb_instr_encoder;
    import rv_pkg::*;

    logic        clk, rst, in_valid, in_ready, in_alt, out_valid, out_ready, out_err;
    logic [3:0]  in_class;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr;
    logic [15:0] enc_count;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_enc = 16'd0;

    instr_encoder #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_funct3 (in_funct3),
        .in_alt    (in_alt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic set_in(input logic [3:0] cls, input logic [2:0] f3, input logic alt,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm);
        in_class  = cls;
        in_funct3 = f3;
        in_alt    = alt;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    // Offer one word into an empty buffer with out_ready=1 and check the one-cycle result.
    task automatic offer(input string tag, input logic [31:0] exp_instr, input logic exp_err);
        in_valid = 1'b1;
        #1 chk({tag, "_pre_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        if (!exp_err) exp_enc++;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_instr"}, out_instr, exp_instr);
        chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
        chk({tag, "_enc"}, 32'(enc_count), 32'(exp_enc));
        @(negedge clk);
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_in(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_enc", 32'(enc_count), 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        set_in(CLS_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        offer("addi", 32'h00500093, 1'b0);
        set_in(CLS_R, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        offer("sub", 32'h402081B3, 1'b0);
        set_in(CLS_LUI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        offer("lui", 32'h123452B7, 1'b0);
        set_in(CLS_JAL, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        offer("jal", 32'h008000EF, 1'b0);
        set_in(CLS_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
        offer("beq_odd", 32'h0, 1'b1);
        set_in(CLS_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        offer("beq", 32'h00208463, 1'b0);
        set_in(CLS_STORE, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        offer("sw", 32'h0020A423, 1'b0);
        set_in(CLS_I, 3'b101, 1'b1, 5'd3, 5'd1, 5'd0, 32'd4);
        offer("srai", 32'h4040D193, 1'b0);
        set_in(CLS_I, 3'b001, 1'b0, 5'd3, 5'd1, 5'd0, 32'd32);
        offer("slli_big", 32'h0, 1'b1);
        set_in(CLS_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00000800);
        offer("addi_big", 32'h0, 1'b1);
        set_in(CLS_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800);
        offer("addi_min", 32'h80000093, 1'b0);
        set_in(CLS_BRANCH, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        offer("br_f3", 32'h0, 1'b1);
        set_in(4'd12, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
        offer("bad_cls", 32'h0, 1'b1);

        // Backpressure: three offers, only two fit
        out_ready = 1'b0;
        set_in(CLS_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid = 1'b1;
        #1 chk("bp_rdy0", 32'(in_ready), 32'd1);
        @(negedge clk);
        exp_enc++;
        set_in(CLS_R, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        #1 chk("bp_rdy1", 32'(in_ready), 32'd1);
        @(negedge clk);
        exp_enc++;
        set_in(CLS_LUI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        #1 chk("bp_full", 32'(in_ready), 32'd0);
        chk("bp_head_a", out_instr, 32'h00500093);
        @(negedge clk);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_head_stable", out_instr, 32'h00500093);
        chk("bp_enc", 32'(enc_count), 32'(exp_enc));
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_head_b", out_instr, 32'h402081B3);
        chk("drain_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        exp_enc++;
        in_valid = 1'b0;
        chk("pushpop_valid", 32'(out_valid), 32'd1);
        chk("pushpop_head_c", out_instr, 32'h123452B7);
        chk("pushpop_enc", 32'(enc_count), 32'(exp_enc));
        @(negedge clk);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Reset with two entries buffered, plus an offer coinciding with reset
        out_ready = 1'b0;
        set_in(CLS_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        #1 chk("in_rst_ready", 32'(in_ready), 32'd0);
        chk("in_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        exp_enc = 16'd0;
        chk("rst_flush_valid", 32'(out_valid), 32'd0);
        chk("rst_flush_enc", 32'(enc_count), 32'(exp_enc));
        chk("rst_flush_instr", out_instr, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1 chk("rst_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("rst_ignored_push", 32'(out_valid), 32'd0);
        set_in(CLS_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        offer("recover", 32'h00500093, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
